// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with an oversampling FSM, start/stop validation and a small receive FIFO.
module uart_rx_core #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DIV_W-1:0]                baud_div,
    input  logic                            uart_rx,
    input  logic                            rx_pop,
    input  logic                            err_clr,
    output logic [7:0]                      rx_data,
    output logic                            rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]     rx_level,
    output logic                            rx_busy,
    output logic                            frame_err,
    output logic                            overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t           state;
    logic             s1, s2, hist, rxs;
    logic [DIV_W-1:0] cnt, div_q, div_eff;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic             expire, push, fe_set, full, pop, do_push, ovr_set;

    assign rxs     = s2;
    assign div_eff = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;
    assign expire  = cnt == DIV_W'(1);
    assign push    = (state == STOP) && expire && rxs;
    assign fe_set  = (state == STOP) && expire && !rxs;
    assign full    = level == LW'(FIFO_DEPTH);
    assign pop     = rx_pop && (level != '0);
    assign do_push = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    assign rx_valid = level != '0;
    assign rx_level = level;
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
    assign rx_busy  = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            hist <= 1'b1;
        end else begin
            s1   <= uart_rx;
            s2   <= s1;
            hist <= s2;
        end
    end

    // cnt free-runs down by default; every state that times a bit reloads it on expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            div_q     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= cnt - DIV_W'(1);
            frame_err <= fe_set | (frame_err & ~err_clr);
            case (state)
                IDLE: if (hist && !rxs) begin
                    div_q <= div_eff;
                    cnt   <= div_eff >> 1;
                    state <= START;
                end
                START: if (expire) begin
                    if (rxs) begin
                        state <= IDLE;
                    end else begin
                        cnt     <= div_q;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: if (expire) begin
                    shift[bit_idx] <= rxs;
                    cnt            <= div_q;
                    bit_idx        <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= STOP;
                end
                STOP: if (expire) state <= rxs ? IDLE : BRK;
                BRK:  if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level   <= level + LW'(do_push) - LW'(pop);
            overrun <= ovr_set | (overrun & ~err_clr);
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames against uart_rx_core with hand-computed expectations.
module tb_uart_rx_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_div = 16'd8;
    logic        uart_rx = 1'b1;
    logic        rx_pop = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [2:0]  rx_level;
    logic        rx_busy;
    logic        frame_err;
    logic        overrun;

    int n_checks = 0;
    int n_fail = 0;

    uart_rx_core #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .uart_rx(uart_rx),
        .rx_pop(rx_pop), .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_level(rx_level), .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int n, input logic stop);
        uart_rx = 1'b0;
        idle(n);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(n);
        end
        uart_rx = stop;
        idle(n);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {8'h0, rx_data}, {8'h0, exp});
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_valid", {15'h0, rx_valid}, 16'h0);
        check("rst_level", {13'h0, rx_level}, 16'h0);
        check("rst_data", {8'h0, rx_data}, 16'h0);
        check("rst_busy", {15'h0, rx_busy}, 16'h0);
        check("rst_flags", {14'h0, frame_err, overrun}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        send_frame(8'h55, 8, 1'b1);
        idle(3);
        check("t1_valid", {15'h0, rx_valid}, 16'h1);
        check("t1_data", {8'h0, rx_data}, 16'h55);
        check("t1_level", {13'h0, rx_level}, 16'h1);
        check("t1_ferr", {15'h0, frame_err}, 16'h0);
        pop_check("t1_pop", 8'h55);
        check("t1_valid_after_pop", {15'h0, rx_valid}, 16'h0);
        check("t1_level_after_pop", {13'h0, rx_level}, 16'h0);

        uart_rx = 1'b0;
        idle(2);
        uart_rx = 1'b1;
        idle(1);
        check("t2_busy_in_start", {15'h0, rx_busy}, 16'h1);
        idle(10);
        check("t2_busy_idle", {15'h0, rx_busy}, 16'h0);
        check("t2_level", {13'h0, rx_level}, 16'h0);
        check("t2_flags", {14'h0, frame_err, overrun}, 16'h0);
        send_frame(8'hA5, 8, 1'b1);
        idle(3);
        pop_check("t2_data", 8'hA5);

        send_frame(8'hC3, 8, 1'b0);
        idle(32);
        check("t3_ferr", {15'h0, frame_err}, 16'h1);
        check("t3_level", {13'h0, rx_level}, 16'h0);
        check("t3_busy_brk", {15'h0, rx_busy}, 16'h1);
        uart_rx = 1'b1;
        idle(4);
        check("t3_busy_released", {15'h0, rx_busy}, 16'h0);
        send_frame(8'h3C, 8, 1'b1);
        idle(3);
        check("t3_ferr_sticky", {15'h0, frame_err}, 16'h1);
        pop_check("t3_data", 8'h3C);
        clear_errs();
        check("t3_ferr_cleared", {15'h0, frame_err}, 16'h0);

        send_frame(8'h11, 8, 1'b1);
        send_frame(8'h22, 8, 1'b1);
        send_frame(8'h33, 8, 1'b1);
        send_frame(8'h44, 8, 1'b1);
        send_frame(8'h55, 8, 1'b1);
        idle(3);
        check("t4_level_full", {13'h0, rx_level}, 16'h4);
        check("t4_overrun", {15'h0, overrun}, 16'h1);
        pop_check("t4_pop0", 8'h11);
        pop_check("t4_pop1", 8'h22);
        pop_check("t4_pop2", 8'h33);
        pop_check("t4_pop3", 8'h44);
        check("t4_level_empty", {13'h0, rx_level}, 16'h0);
        clear_errs();
        check("t4_overrun_cleared", {15'h0, overrun}, 16'h0);

        send_frame(8'h11, 8, 1'b1);
        send_frame(8'h22, 8, 1'b1);
        send_frame(8'h33, 8, 1'b1);
        send_frame(8'h44, 8, 1'b1);
        // stop sample of a frame starting at T lands in the cycle ending at T+785
        fork
            send_frame(8'h55, 8, 1'b1);
            begin
                idle(78);
                rx_pop = 1'b1;
                @(negedge clk);
                rx_pop = 1'b0;
            end
        join
        idle(3);
        check("t5_overrun", {15'h0, overrun}, 16'h0);
        check("t5_level", {13'h0, rx_level}, 16'h4);
        pop_check("t5_pop0", 8'h22);
        pop_check("t5_pop1", 8'h33);
        pop_check("t5_pop2", 8'h44);
        pop_check("t5_pop3", 8'h55);

        baud_div = 16'd2;
        idle(2);
        send_frame(8'hFF, 4, 1'b1);
        idle(3);
        check("t6_valid", {15'h0, rx_valid}, 16'h1);
        check("t6_data", {8'h0, rx_data}, 16'hFF);
        check("t6_ferr", {15'h0, frame_err}, 16'h0);

        baud_div = 16'd8;
        idle(2);
        uart_rx = 1'b0;
        idle(8);
        uart_rx = 1'b0;
        idle(8);
        uart_rx = 1'b1;
        idle(8);
        uart_rx = 1'b0;
        idle(4);
        check("t7_busy_pre", {15'h0, rx_busy}, 16'h1);
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", {15'h0, rx_valid}, 16'h0);
        check("t7_rst_level", {13'h0, rx_level}, 16'h0);
        check("t7_rst_data", {8'h0, rx_data}, 16'h0);
        check("t7_rst_busy", {15'h0, rx_busy}, 16'h0);
        @(negedge clk);
        uart_rx = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(20);
        check("t7_idle_after", {15'h0, rx_busy}, 16'h0);
        send_frame(8'h00, 8, 1'b1);
        idle(3);
        check("t7_valid", {15'h0, rx_valid}, 16'h1);
        check("t7_data", {8'h0, rx_data}, 16'h00);
        check("t7_level", {13'h0, rx_level}, 16'h1);
        check("t7_flags", {14'h0, frame_err, overrun}, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
